// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with mid-bit sampling, FWFT FIFO and sticky error flags
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_core #(
`ifdef UART_RX_PARITY_EN
    parameter bit PARITY_ODD = 1'b0,
`endif
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       clr_err
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MID  = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rx_meta_q, rx_s_q;
    logic            push, ferr_set, perr_set;
    logic            frame_err_q, overrun_q, parity_err_q;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            pop, full, wr_ok, ovr_set;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_END) begin
                    cnt_d    = '0;
                    perr_set = (^shreg_q) ^ rx_s_q ^ PARITY_ODD;
                    state_d  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A push into a full FIFO is only accepted when a pop frees the head in the same cycle.
    always_comb begin
        pop     = rd_en && (count_q != '0);
        full    = (count_q == FULL_CNT);
        wr_ok   = push && (!full || pop);
        ovr_set = push && full && !pop;
        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shreg_q      <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            count_q      <= count_d;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            frame_err_q  <= ferr_set | (frame_err_q & ~clr_err);
            overrun_q    <= ovr_set  | (overrun_q & ~clr_err);
            parity_err_q <= perr_set | (parity_err_q & ~clr_err);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[wr_ptr_q] <= shreg_q;
    end

    assign rd_valid  = (count_q != '0);
    assign rd_data   = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed scoreboard bench for uart_rx_core (CLKS_PER_BIT=10, FIFO_DEPTH=4)
module tb_uart_rx_core;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Stop bit is sampled at the NB*10-2'th rising edge after the start bit is driven.
    localparam int LAT = NB * 10 - 2;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];

    always #5 sys_clk = ~sys_clk;

    uart_rx_core #(
        .CLK_HZ(12_000_000),
        .BAUD(1_200_000),
        .FIFO_DEPTH(4)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .clr_err  (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop_b, input logic end_b,
                        input logic lat_chk, input logic pop_on_push);
        logic [NB-1:0] bits;
        logic [7:0]    head;
`ifdef UART_RX_PARITY_EN
        bits = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {stop_b, d, 1'b0};
`endif
        uart_rx = bits[0];
        for (int k = 1; k <= NB * 10; k++) begin
            @(posedge sys_clk);
            #1;
            if (lat_chk && k == LAT - 1) begin
                chk("pre_push_valid", rd_valid, 1'b0);
                chk("pre_push_busy", busy, 1'b1);
            end
            if (lat_chk && k == LAT) begin
                chk("push_valid", rd_valid, 1'b1);
                chk("push_data", rd_data, d);
                chk("idle_after_stop", busy, 1'b0);
            end
            if (pop_on_push && k == LAT - 1) begin
                head  = sb.pop_front();
                chk("head_before_pop", rd_data, head);
                rd_en = 1'b1;
            end
            if (pop_on_push && k == LAT) rd_en = 1'b0;
            uart_rx = (k == NB * 10) ? end_b : bits[k / 10];
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk({tag, "_valid"}, rd_valid, 1'b1);
        chk({tag, "_data"}, rd_data, exp);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rst = 1'b1;
        cyc(3);

        // basic frame with exact push latency
        sb.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_ferr", frame_err, 1'b0);
        chk("t1_ovr", overrun, 1'b0);
        pop_check("t1");
        chk("t1_empty", rd_valid, 1'b0);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        chk("t1_empty_pop_valid", rd_valid, 1'b0);
        chk("t1_empty_pop_data", rd_data, 8'h00);

        // short glitch rejected
        uart_rx = 1'b0;
        cyc(3);
        uart_rx = 1'b1;
        cyc(2);
        chk("t2_busy_start", busy, 1'b1);
        cyc(10);
        chk("t2_busy_idle", busy, 1'b0);
        chk("t2_empty", rd_valid, 1'b0);
        chk("t2_ferr", frame_err, 1'b0);

        // framing error then break then good frame
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(30);
        chk("t3_ferr", frame_err, 1'b1);
        chk("t3_break_busy", busy, 1'b1);
        chk("t3_no_push", rd_valid, 1'b0);
        uart_rx = 1'b1;
        cyc(5);
        chk("t3_idle", busy, 1'b0);
        sb.push_back(8'h81);
        send(8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(2);
        pop_check("t3");
        chk("t3_only_one", rd_valid, 1'b0);
        clear_flags();
        chk("t3_ferr_clr", frame_err, 1'b0);

        // overrun: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            send(8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        cyc(2);
        chk("t4_ovr", overrun, 1'b1);
        for (int i = 0; i < 4; i++) pop_check("t4");
        chk("t4_empty", rd_valid, 1'b0);
        clear_flags();
        chk("t4_ovr_clr", overrun, 1'b0);

        // full FIFO with pop on the push cycle
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(8'(i));
            send(8'(i), 1'b1, 1'b1, 1'b0, i == 5);
        end
        cyc(2);
        chk("t5_ovr", overrun, 1'b0);
        for (int i = 0; i < 4; i++) pop_check("t5");
        chk("t5_empty", rd_valid, 1'b0);

        // reset mid-frame with a byte queued
        send(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        uart_rx = 1'b0;
        cyc(10);
        uart_rx = 1'b1;
        cyc(25);
        chk("t6_busy_pre", busy, 1'b1);
        chk("t6_valid_pre", rd_valid, 1'b1);
        rst = 1'b0;
        cyc(1);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_valid", rd_valid, 1'b0);
        chk("t6_rst_data", rd_data, 8'h00);
        chk("t6_rst_ferr", frame_err, 1'b0);
        rst = 1'b1;
        cyc(3);
        sb.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(2);
        pop_check("t6");
        chk("t6_ferr", frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
        chk("par_clean", parity_err, 1'b0);
        par_flip = 1'b1;
        sb.push_back(8'h07);
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        par_flip = 1'b0;
        cyc(2);
        chk("par_err", parity_err, 1'b1);
        pop_check("par");
        clear_flags();
        chk("par_clr", parity_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
